// File: rtl/uart_frame_parser.sv
`default_nettype none
// ============================================================================
// Module   : uart_frame_parser
// Brief    : Decodes AA 55 LEN payload CHK frames from a UART byte stream.
// Revision : 1.0 - initial release
// ============================================================================
module uart_frame_parser #(
  parameter int MAX_LEN = 16,
  parameter int TIMEOUT = 500000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rx_data,
  input  logic       rx_int,
  input  logic [3:0] rd_addr,
  input  logic       frame_ack,
  output logic [7:0] rd_data,
  output logic [4:0] frame_len,
  output logic       frame_done,
  output logic       frame_err,
  output logic [1:0] err_code,
  output logic       overrun,
  output logic       busy
);

  localparam int              TW        = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0]   TMO_LAST  = TW'(TIMEOUT - 1);
  localparam logic [7:0]      MAX_LEN_B = 8'(MAX_LEN);
  localparam logic [4:0]      MAX_LEN_A = 5'(MAX_LEN);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_HDR2    = 3'd1;
  localparam logic [2:0] S_LEN     = 3'd2;
  localparam logic [2:0] S_PAYLOAD = 3'd3;
  localparam logic [2:0] S_CHK     = 3'd4;
  localparam logic [2:0] S_LOCKED  = 3'd5;

  logic [2:0]    state_q, state_d;
  logic          rx_int_q;
  logic [4:0]    len_q, len_d;
  logic [7:0]    sum_q, sum_d;
  logic [3:0]    idx_q, idx_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [4:0]    frame_len_q, frame_len_d;
  logic          frame_done_q, frame_done_d;
  logic          frame_err_q, frame_err_d;
  logic [1:0]    err_code_q, err_code_d;
  logic          overrun_q, overrun_d;
  logic [7:0]    rd_data_q, rd_data_d;
  logic [7:0]    mem_q [MAX_LEN];

  logic w_byte_stb;
  logic w_counting;
  logic w_tmo_hit;
  logic w_len_bad;
  logic w_last;
  logic w_wr_en;
  logic w_busy;

  assign w_byte_stb = rx_int_q & ~rx_int;
  assign w_counting = (state_q == S_HDR2) || (state_q == S_LEN) ||
                      (state_q == S_PAYLOAD) || (state_q == S_CHK);
  // A byte arriving on the terminal count wins over the timeout.
  assign w_tmo_hit  = w_counting && !w_byte_stb && (tmo_q == TMO_LAST);
  assign w_len_bad  = (rx_data == 8'd0) || (rx_data > MAX_LEN_B);
  assign w_last     = ({1'b0, idx_q} == (len_q - 5'd1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      rx_int_q     <= 1'b0;
      len_q        <= '0;
      sum_q        <= '0;
      idx_q        <= '0;
      tmo_q        <= '0;
      frame_len_q  <= '0;
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
      err_code_q   <= '0;
      overrun_q    <= 1'b0;
      rd_data_q    <= '0;
    end else begin
      state_q      <= state_d;
      rx_int_q     <= rx_int;
      len_q        <= len_d;
      sum_q        <= sum_d;
      idx_q        <= idx_d;
      tmo_q        <= tmo_d;
      frame_len_q  <= frame_len_d;
      frame_done_q <= frame_done_d;
      frame_err_q  <= frame_err_d;
      err_code_q   <= err_code_d;
      overrun_q    <= overrun_d;
      rd_data_q    <= rd_data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      mem_q[idx_q] <= rx_data;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (w_byte_stb && rx_data == 8'hAA) state_d = S_HDR2;
      end
      S_HDR2: begin
        if (w_byte_stb) begin
          if (rx_data == 8'h55)      state_d = S_LEN;
          else if (rx_data == 8'hAA) state_d = S_HDR2;
          else                       state_d = S_IDLE;
        end
      end
      S_LEN: begin
        if (w_byte_stb) state_d = w_len_bad ? S_IDLE : S_PAYLOAD;
      end
      S_PAYLOAD: begin
        if (w_byte_stb && w_last) state_d = S_CHK;
      end
      S_CHK: begin
        if (w_byte_stb) state_d = (rx_data == sum_q) ? S_LOCKED : S_IDLE;
      end
      S_LOCKED: begin
        if (frame_ack) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (w_tmo_hit) state_d = S_IDLE;
  end

  always_comb begin
    len_d        = len_q;
    sum_d        = sum_q;
    idx_d        = idx_q;
    frame_len_d  = frame_len_q;
    frame_done_d = 1'b0;
    frame_err_d  = 1'b0;
    err_code_d   = err_code_q;
    overrun_d    = 1'b0;
    w_wr_en      = 1'b0;
    w_busy       = (state_q != S_IDLE);
    rd_data_d    = ({1'b0, rd_addr} < MAX_LEN_A) ? mem_q[rd_addr] : 8'h00;

    if (!w_counting || w_byte_stb || w_tmo_hit) tmo_d = '0;
    else                                        tmo_d = tmo_q + 1'b1;

    if (w_byte_stb) begin
      case (state_q)
        S_LEN: begin
          if (w_len_bad) begin
            frame_err_d = 1'b1;
            err_code_d  = 2'd1;
          end else begin
            len_d = rx_data[4:0];
            sum_d = rx_data;
            idx_d = '0;
          end
        end
        S_PAYLOAD: begin
          w_wr_en = 1'b1;
          sum_d   = sum_q + rx_data;
          idx_d   = idx_q + 4'd1;
        end
        S_CHK: begin
          if (rx_data == sum_q) begin
            frame_len_d  = len_q;
            frame_done_d = 1'b1;
          end else begin
            frame_err_d = 1'b1;
            err_code_d  = 2'd2;
          end
        end
        S_LOCKED: overrun_d = 1'b1;
        default: ;
      endcase
    end

    if (w_tmo_hit) begin
      frame_err_d = 1'b1;
      err_code_d  = 2'd3;
    end
  end

  assign rd_data    = rd_data_q;
  assign frame_len  = frame_len_q;
  assign frame_done = frame_done_q;
  assign frame_err  = frame_err_q;
  assign err_code   = err_code_q;
  assign overrun    = overrun_q;
  assign busy       = w_busy;

endmodule
`default_nettype wire

// File: tb/tb_uart_frame_parser.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_frame_parser
// Brief    : Directed self-checking bench for uart_frame_parser.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_frame_parser;

  localparam int TMO = 64;

  logic       clk;
  logic       rst_n;
  logic [7:0] rx_data;
  logic       rx_int;
  logic [3:0] rd_addr;
  logic       frame_ack;
  logic [7:0] rd_data;
  logic [4:0] frame_len;
  logic       frame_done;
  logic       frame_err;
  logic [1:0] err_code;
  logic       overrun;
  logic       busy;

  int errors = 0;
  int checks = 0;

  logic       s_done, s_err, s_ovr, s_pulse2;
  logic [1:0] s_code;
  logic [7:0] rd_val;
  int         tmo_at;

  uart_frame_parser #(.MAX_LEN(16), .TIMEOUT(TMO)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx_data   (rx_data),
    .rx_int    (rx_int),
    .rd_addr   (rd_addr),
    .frame_ack (frame_ack),
    .rd_data   (rd_data),
    .frame_len (frame_len),
    .frame_done(frame_done),
    .frame_err (frame_err),
    .err_code  (err_code),
    .overrun   (overrun),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Strobe lands in the cycle after rx_int falls; capture the registered
  // pulses one cycle later and again the cycle after that.
  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    rx_data = b;
    rx_int  = 1'b1;
    repeat (2) @(posedge clk);
    #1 rx_int = 1'b0;
    @(posedge clk);
    @(negedge clk);
    s_done = frame_done;
    s_err  = frame_err;
    s_ovr  = overrun;
    s_code = err_code;
    @(negedge clk);
    s_pulse2 = frame_done | frame_err | overrun;
  endtask

  task automatic read_buf(input logic [3:0] a, output logic [7:0] v);
    @(posedge clk); #1;
    rd_addr = a;
    @(posedge clk);
    @(negedge clk);
    v = rd_data;
  endtask

  task automatic ack();
    @(posedge clk); #1 frame_ack = 1'b1;
    @(posedge clk); #1 frame_ack = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; rx_data = 8'h00; rx_int = 1'b0; rd_addr = 4'd0; frame_ack = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", frame_done, 0);
    check("rst_err", frame_err, 0);
    check("rst_code", err_code, 0);
    check("rst_len", frame_len, 0);
    check("rst_rd", rd_data, 0);
    check("rst_ovr", overrun, 0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Good 3-byte frame
    send_byte(8'hAA); send_byte(8'h55); send_byte(8'h03);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    check("f1_busy_pre", busy, 1);
    send_byte(8'h69);
    check("f1_done", s_done, 1);
    check("f1_err", s_err, 0);
    check("f1_pulse_once", s_pulse2, 0);
    check("f1_len", frame_len, 3);
    check("f1_busy_locked", busy, 1);
    read_buf(4'd0, rd_val); check("f1_b0", rd_val, 8'h11);
    read_buf(4'd1, rd_val); check("f1_b1", rd_val, 8'h22);
    read_buf(4'd2, rd_val); check("f1_b2", rd_val, 8'h33);

    // Bytes while locked are dropped with overrun
    send_byte(8'h77);
    check("ovr1", s_ovr, 1);
    check("ovr1_once", s_pulse2, 0);
    send_byte(8'h88);
    check("ovr2", s_ovr, 1);
    check("ovr_busy", busy, 1);
    read_buf(4'd0, rd_val); check("ovr_b0", rd_val, 8'h11);
    read_buf(4'd1, rd_val); check("ovr_b1", rd_val, 8'h22);
    read_buf(4'd2, rd_val); check("ovr_b2", rd_val, 8'h33);
    ack();
    check("ack_idle", busy, 0);

    // Checksum mismatch (expected 32)
    send_byte(8'hAA); send_byte(8'h55); send_byte(8'h02);
    send_byte(8'h10); send_byte(8'h20); send_byte(8'h33);
    check("chk_err", s_err, 1);
    check("chk_code", s_code, 2);
    check("chk_done", s_done, 0);
    check("chk_len_kept", frame_len, 3);
    check("chk_busy", busy, 0);

    // Bad lengths 0 and 17
    send_byte(8'hAA); send_byte(8'h55); send_byte(8'h00);
    check("len0_err", s_err, 1);
    check("len0_code", s_code, 1);
    check("len0_busy", busy, 0);
    send_byte(8'hAA); send_byte(8'h55); send_byte(8'h11);
    check("len17_err", s_err, 1);
    check("len17_code", s_code, 1);

    // Resync on leading junk and repeated AA; checksum wraps to 00
    send_byte(8'h12); send_byte(8'hAA); send_byte(8'hAA); send_byte(8'h55);
    send_byte(8'h01); send_byte(8'hFF); send_byte(8'h00);
    check("wrap_done", s_done, 1);
    check("wrap_len", frame_len, 1);
    read_buf(4'd0, rd_val); check("wrap_b0", rd_val, 8'hFF);
    check("err_code_held", err_code, 1);
    ack();

    // Inter-byte timeout mid-payload
    send_byte(8'hAA); send_byte(8'h55); send_byte(8'h04); send_byte(8'h01);
    tmo_at = -1;
    for (int n = 2; n <= TMO + 10; n++) begin
      @(negedge clk);
      if (frame_err && tmo_at < 0) tmo_at = n;
    end
    check("tmo_cycle", tmo_at, TMO);
    check("tmo_code", err_code, 3);
    check("tmo_busy", busy, 0);

    // Good frame after timeout
    send_byte(8'hAA); send_byte(8'h55); send_byte(8'h02);
    send_byte(8'h05); send_byte(8'h06); send_byte(8'h0D);
    check("post_tmo_done", s_done, 1);
    check("post_tmo_len", frame_len, 2);
    read_buf(4'd1, rd_val); check("post_tmo_b1", rd_val, 8'h06);
    ack();

    // Reset mid-payload
    send_byte(8'hAA); send_byte(8'h55); send_byte(8'h03); send_byte(8'h01);
    @(posedge clk); #1 rst_n = 1'b0;
    @(negedge clk);
    check("mrst_busy", busy, 0);
    check("mrst_len", frame_len, 0);
    check("mrst_code", err_code, 0);
    check("mrst_rd", rd_data, 0);
    check("mrst_err", frame_err, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    send_byte(8'hAA); send_byte(8'h55); send_byte(8'h01);
    send_byte(8'h42); send_byte(8'h43);
    check("mrst_next_done", s_done, 1);
    check("mrst_next_len", frame_len, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_frame_parser.md
# uart_frame_parser

Byte-stream frame decoder sitting directly downstream of the UART receiver. It consumes each received byte on the falling edge of the receiver's `rx_int` and hunts for the `0xAA 0x55` header. It then collects a length-prefixed payload into an internal buffer and verifies an 8-bit additive checksum. Each completed frame is flagged, and its payload is held for the host logic to read and then release.

## Interface
- `MAX_LEN`, 16: maximum payload bytes; legal range 1..16.
- `TIMEOUT`, 500000: inter-byte gap limit in `clk` cycles (10 ms at 50 MHz).
- `clk`  in  1  50 MHz system clock.
- `rst_n`  in  1  Reset. One clock; reset is asynchronous and active-low.
- `rx_data`  in  8  Received byte from the UART receiver, stable from its latch until the next byte completes.
- `rx_int`  in  1  Receiver busy flag; its high-to-low edge marks `rx_data` valid.
- `rd_addr`  in  4  Payload buffer read address.
- `frame_ack`  in  1  Host releases the locked buffer (1-cycle pulse).
- `rd_data`  out  8  Payload byte at `rd_addr`, registered.
- `frame_len`  out  5  Payload length of the last good frame.
- `frame_done`  out  1  1-cycle pulse: good frame locked.
- `frame_err`  out  1  1-cycle pulse: frame aborted.
- `err_code`  out  2  Error cause, valid with `frame_err`: 1 = bad length, 2 = checksum, 3 = timeout.
- `overrun`  out  1  1-cycle pulse: byte dropped while locked.
- `busy`  out  1  High whenever the state is not IDLE.

## Operation
- Frame format: `0xAA`, `0x55`, LEN, then LEN payload bytes, then CHK.
  - CHK = (LEN + sum of payload) mod 256.
- Byte strobe:
  - `rx_int_d` is a register copy of `rx_int`.
  - `byte_stb` = `rx_int_d & ~rx_int`, combinational.
- States and transitions on `byte_stb`:
  - **IDLE**: a byte of `0xAA` moves to HDR2; anything else stays in IDLE.
  - **HDR2**:
    - `0x55` moves to LEN.
    - `0xAA` stays in HDR2 (resync).
    - Anything else returns to IDLE silently.
  - **LEN**:
    - A value of 0 or greater than `MAX_LEN` raises `frame_err`, code 1, and returns to IDLE.
    - Otherwise the length is stored, the sum is seeded with LEN, the write index is cleared, and the state moves to PAYLOAD.
  - **PAYLOAD**:
    - Each byte is written to buffer[index], added to the sum, and the index is incremented.
    - After the LENth byte the state moves to CHK.
  - **CHK**:
    - Match: `frame_len` is updated, `frame_done` pulses, and the state moves to LOCKED.
    - Mismatch: `frame_err` pulses with code 2, the state returns to IDLE, and `frame_len` is unchanged.
  - **LOCKED**:
    - Buffer writes are inhibited and every `byte_stb` pulses `overrun`.
    - `frame_ack` returns the state to IDLE.
- Timeout:
  - A counter is cleared on every `byte_stb` and increments in HDR2, LEN, PAYLOAD and CHK.
  - When it reaches `TIMEOUT-1`, `frame_err` pulses with code 3 and the state returns to IDLE.
  - The counter is held at 0 in IDLE and LOCKED.
- Arithmetic: the sum is 8-bit and wraps; the index is 4-bit.
- Buffer contents after an error are undefined. `rd_data` is meaningful only while LOCKED.
- `frame_ack` outside LOCKED is ignored.

## Timing
- Reset values: state IDLE, all pulses 0, `err_code` 0, `frame_len` 0, `rd_data` 0, `busy` 0, `rx_int_d` 0.
- `byte_stb` is high in the first cycle that `rx_int` reads 0 after reading 1.
- State, buffer and sum update on the `clk` edge ending the strobe cycle.
- `frame_done`, `frame_err` and `overrun` are registered. They are high exactly one cycle, in the cycle after the triggering strobe or timeout.
- `err_code` is registered alongside `frame_err` and holds until the next error.
- `rd_data` latency is 1 cycle from `rd_addr`.
- Simultaneous events:
  - `byte_stb` and timeout terminal count: the byte wins, the counter clears, and no error is raised.
  - `frame_ack` and `byte_stb` in LOCKED: the state goes to IDLE, the byte is dropped, and `overrun` pulses.
- Reset mid-frame aborts immediately, with no error pulse.

## Test plan
- Send `AA 55 03 11 22 33 69` → `frame_done` 1 cycle, `frame_len`=3, and `rd_addr` 0/1/2 read `11`/`22`/`33`.
- Send `AA 55 02 10 20 33` (expected CHK is `32`) → `frame_err`, `err_code`=2, `frame_len` unchanged, `busy`=0.
- Send `AA 55 00`, then `AA 55 11` → `frame_err` with `err_code`=1 both times.
- Send `12 AA AA 55 01 FF 00` → `frame_done`, `frame_len`=1, buffer[0]=`FF` (checksum wraps).
- Send `AA 55 04 01`, then idle for `TIMEOUT` cycles → `frame_err`, `err_code`=3; a following good frame decodes.
- With a frame locked, send 2 bytes → 2 `overrun` pulses and the buffer is intact. After `frame_ack`, the next frame decodes; reset asserted mid-payload returns all outputs to reset values.
